lieat_sram_rd_arb: RTL and testbench
====================================

Name: lieat_sram_rd_arb

Overview:
Read-path arbiter that sits directly upstream of the SRAM AXI slave's AR/R channels.
It merges two read masters into one outstanding read at a time: M0 is instruction fetch (IFU) and M1 is the load unit (LSU).
Each grant is issued on the slave AR channel with a per-master ARID.
The matching R beat is routed back to the granted master only.
The write channels are not part of this block; they stay LSU→SRAM direct.

Parameters:
M0_ID, 4'd0, ARID driven for M0 requests
M1_ID, 4'd1, ARID driven for M1 requests
M0_SIZE, 3'b010, fixed ARSIZE for M0 (word fetch)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m0_arvalid  in  1  IFU read request
m0_arready  out  1  IFU request accepted
m0_araddr  in  `XLEN  IFU address
m0_rvalid  out  1  IFU read data valid
m0_rready  in  1  IFU accepts data
m0_rdata  out  `XLEN  IFU read data
m1_arvalid  in  1  LSU read request
m1_arready  out  1  LSU request accepted
m1_araddr  in  `XLEN  LSU address
m1_arsize  in  3  LSU size (3'b000/001/010)
m1_rvalid  out  1  LSU read data valid
m1_rready  in  1  LSU accepts data
m1_rdata  out  `XLEN  LSU read data
s_arvalid  out  1  to SRAM AR
s_arready  in  1  from SRAM AR
s_araddr  out  `XLEN  registered granted address
s_arsize  out  3  registered granted size
s_arid  out  4  M0_ID or M1_ID
s_rvalid  in  1  from SRAM R
s_rready  out  1  to SRAM R
s_rdata  in  `XLEN  SRAM read data
s_rid  in  4  SRAM read id (not used for routing)

Behaviour:
- Reset: synchronous, active-high.
  - State goes to IDLE; owner=M0; last_grant=M1, so M0 wins the first tie.
  - s_arvalid=0; all m*_rvalid=0; m*_arready follow the IDLE combinational rule below.
- Arbitration happens only in IDLE.
  - Only one valid: that master is granted.
  - Both valid: grant the master not equal to last_grant (round-robin).
  - m<g>_arready=1 combinationally for the granted master only. The other master's arready=0. Outside IDLE, both arready=0.
- Master AR handshake in IDLE:
  - Latch addr and size: M0 uses M0_SIZE, M1 uses m1_arsize.
  - Latch arid = M<g>_ID and owner=g.
  - Go to AR.
- AR state:
  - s_arvalid=1 with the latched fields, held stable until s_arready.
  - On handshake go to R; latency is master AR handshake at cycle N → s_arvalid high at N+1.
- R state:
  - s_rready = owner's m_rready.
  - Owner's m_rvalid = s_rvalid; the non-owner's m_rvalid=0.
  - Both m*_rdata = s_rdata combinationally.
  - On the s_rvalid&s_rready handshake: last_grant←owner, go to IDLE.
  - A new grant can handshake in that IDLE cycle.
- Minimum turnaround is 3 cycles per transaction plus SRAM delay. No pipelining; at most one read is outstanding.
- A master that drops arvalid before its handshake loses nothing: the grant is recomputed every IDLE cycle.
- A reset asserted in AR or R abandons the transaction: IDLE and m*_rvalid=0 the next cycle. The SRAM is reset on the same rst, so no stale beat is expected.
- s_rid is ignored for routing. Simulation assertion: at each R handshake, s_rid == latched arid.
- States: IDLE(2'd0), AR(2'd1), R(2'd2). 2'd3 is unreachable and decodes to IDLE.

Decomposition:
- Shared package/header (`lieat_defines`): `XLEN, state encodings, default M0_ID/M1_ID, AXI size codes SIZE_B/H/W.
- Sub-module: lieat_rr_arb2, a 2-input round-robin grant with last_grant register.
- State, owner and AR payload registers use the team's general DFF cells.

Test Plan:
1. Reset held 2 cycles, no requests → s_arvalid=0, m0/m1_rvalid=0, m0/m1_arready=0.
2. Single M0 read:
   - Stimulus: 0x8000_0000; SRAM returns 0xDEAD_BEEF.
   - Response: s_araddr=0x8000_0000, s_arsize=3'b010, s_arid=0. m0_rdata=0xDEAD_BEEF with m0_rvalid=1; m1_rvalid stays 0.
3. Tie sequence:
   - Stimulus: M0 and M1 both hold arvalid for 4 back-to-back reads.
   - Response: grants alternate M0,M1,M0,M1; s_arid sequence 0,1,0,1.
4. M1 byte read:
   - Stimulus: addr 0x8000_0003, m1_arsize=3'b000.
   - Response: s_arsize=3'b000, s_arid=1, data returned only to m1.
5. Backpressure:
   - Stimulus: m0_rready low 3 cycles while s_rvalid=1; m1_arvalid=1 throughout.
   - Response: s_rready=0, m0_rvalid=1, m1_arready=0 for those cycles. M1 is granted the cycle after the M0 R handshake.
6. Reset pulse in R state with s_rvalid low → next cycle state IDLE, m*_rvalid=0. A fresh M1 request then completes normally.

Source files
------------

// File: rtl/lieat_sram_rd_arb_pkg.sv
// ---------------------------------------------------------------------------
// lieat_sram_rd_arb_pkg
// Shared definitions for the SRAM read-path arbiter:
//   - XLEN           : data/address width of the read path
//   - SIZE_B/H/W     : AXI ARSIZE codes for byte, halfword and word accesses
//   - M0_ID_DEF/M1_ID_DEF : default ARIDs for the IFU and LSU masters
//   - rd_state_e     : arbiter FSM encoding (2'd3 is unreachable)
//   - ar_req_t       : latched AR payload (address, size, id)
// ---------------------------------------------------------------------------
package lieat_sram_rd_arb_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] SIZE_B = 3'b000;
    localparam logic [2:0] SIZE_H = 3'b001;
    localparam logic [2:0] SIZE_W = 3'b010;

    localparam logic [3:0] M0_ID_DEF = 4'd0;
    localparam logic [3:0] M1_ID_DEF = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_AR     = 2'd1,
        ST_R      = 2'd2,
        ST_UNUSED = 2'd3
    } rd_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [2:0]      size;
        logic [3:0]      id;
    } ar_req_t;

endpackage

// File: rtl/lieat_sram_rd_arb_rr.sv
// ---------------------------------------------------------------------------
// lieat_rr_arb2
// Two-input round-robin grant with its own last_grant register.
//   clk, rst   : clock, synchronous active-high reset
//   req[1:0]   : request vector (bit 0 = M0, bit 1 = M1)
//   upd        : pulse to record a completed grant
//   upd_idx    : index of the master that completed
//   gnt_vld    : at least one request present
//   gnt_idx    : index of the granted master (valid when gnt_vld)
// last_grant resets to M1 so that M0 wins the first tie.
// ---------------------------------------------------------------------------
module lieat_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    logic last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (upd) begin
            last_q <= upd_idx;
        end
    end

    // A lone requester always wins; on a tie the master that did not
    // complete most recently wins.
    always_comb begin
        gnt_vld = |req;
        gnt_idx = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~last_q;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/lieat_sram_rd_arb.sv
// ---------------------------------------------------------------------------
// lieat_sram_rd_arb
// Merges the IFU (M0) and LSU (M1) read masters onto the single SRAM AXI
// AR/R channel pair, one outstanding read at a time.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   m0_ar{valid,ready,addr}    IFU read request (size fixed to M0_SIZE)
//   m0_r{valid,ready,data}     IFU read response
//   m1_ar{valid,ready,addr,size} LSU read request
//   m1_r{valid,ready,data}     LSU read response
//   s_ar{valid,ready,addr,size,id} SRAM read address channel
//   s_r{valid,ready,data,id}   SRAM read data channel (rid not used to route)
//   dbg_state                  current FSM state (IDLE=0, AR=1, R=2)
//
// Handshake semantics: every channel transfers on the cycle where both
// valid and ready are high at the rising edge; a valid source holds its
// payload stable until that cycle.
//
// Flow: IDLE (arbitrate, latch winner's request) -> AR (present to SRAM
// until accepted) -> R (route the single beat to the owner) -> IDLE.
// ---------------------------------------------------------------------------
module lieat_sram_rd_arb
    import lieat_sram_rd_arb_pkg::*;
#(
    parameter logic [3:0] M0_ID   = M0_ID_DEF,
    parameter logic [3:0] M1_ID   = M1_ID_DEF,
    parameter logic [2:0] M0_SIZE = SIZE_W
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_arvalid,
    output logic            m0_arready,
    input  logic [XLEN-1:0] m0_araddr,
    output logic            m0_rvalid,
    input  logic            m0_rready,
    output logic [XLEN-1:0] m0_rdata,

    input  logic            m1_arvalid,
    output logic            m1_arready,
    input  logic [XLEN-1:0] m1_araddr,
    input  logic [2:0]      m1_arsize,
    output logic            m1_rvalid,
    input  logic            m1_rready,
    output logic [XLEN-1:0] m1_rdata,

    output logic            s_arvalid,
    input  logic            s_arready,
    output logic [XLEN-1:0] s_araddr,
    output logic [2:0]      s_arsize,
    output logic [3:0]      s_arid,
    input  logic            s_rvalid,
    output logic            s_rready,
    input  logic [XLEN-1:0] s_rdata,
    input  logic [3:0]      s_rid,

    output logic [1:0]      dbg_state
);

    rd_state_e state_q, state_d;
    logic      owner_q;
    ar_req_t   ar_q;

    logic      gnt_vld;
    logic      gnt_idx;
    logic      is_idle;
    logic      is_ar;
    logic      is_r;
    logic      m_ar_hs;
    logic      r_hs;

    // The unused encoding behaves exactly like IDLE.
    assign is_ar   = (state_q == ST_AR);
    assign is_r    = (state_q == ST_R);
    assign is_idle = !is_ar && !is_r;

    lieat_rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({m1_arvalid, m0_arvalid}),
        .upd     (r_hs),
        .upd_idx (owner_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // The grant only exists when the winner is requesting, so a grant in
    // IDLE is also the master-side AR handshake.
    assign m0_arready = is_idle && gnt_vld && !gnt_idx;
    assign m1_arready = is_idle && gnt_vld &&  gnt_idx;
    assign m_ar_hs    = is_idle && gnt_vld;

    // SRAM side
    assign s_arvalid = is_ar;
    assign s_araddr  = ar_q.addr;
    assign s_arsize  = ar_q.size;
    assign s_arid    = ar_q.id;

    assign s_rready  = is_r && (owner_q ? m1_rready : m0_rready);
    assign m0_rvalid = is_r && !owner_q && s_rvalid;
    assign m1_rvalid = is_r &&  owner_q && s_rvalid;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign r_hs      = is_r && s_rvalid && s_rready;

    assign dbg_state = state_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_AR: begin
                if (s_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (r_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = m_ar_hs ? ST_AR : ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner and AR payload are captured only on the master handshake and
    // stay stable through AR and R.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= 1'b0;
            ar_q    <= '0;
        end else if (m_ar_hs) begin
            owner_q   <= gnt_idx;
            ar_q.addr <= gnt_idx ? m1_araddr : m0_araddr;
            ar_q.size <= gnt_idx ? m1_arsize : M0_SIZE;
            ar_q.id   <= gnt_idx ? M1_ID     : M0_ID;
        end
    end

`ifndef SYNTHESIS
    // The SRAM must answer with the id it was given; routing relies on
    // owner_q alone, so a mismatch means the slave and arbiter disagree.
    a_rid_match: assert property (@(posedge clk) disable iff (rst)
        r_hs |-> (s_rid == ar_q.id));
`endif

endmodule

// File: tb/tb_lieat_sram_rd_arb.sv
module tb_lieat_sram_rd_arb;
  import lieat_sram_rd_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_arvalid = 0, m0_arready, m0_rvalid, m0_rready = 1;
  logic [31:0] m0_araddr = 0, m0_rdata;
  logic        m1_arvalid = 0, m1_arready, m1_rvalid, m1_rready = 1;
  logic [31:0] m1_araddr = 0, m1_rdata;
  logic [2:0]  m1_arsize = 3'b010;
  logic        s_arvalid, s_arready = 0, s_rvalid = 0, s_rready;
  logic [31:0] s_araddr, s_rdata = 0;
  logic [2:0]  s_arsize;
  logic [3:0]  s_arid, s_rid = 0;
  logic [1:0]  dbg_state;

  lieat_sram_rd_arb dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arsize(m1_arsize), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_rdata(m1_rdata),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arsize(s_arsize), .s_arid(s_arid), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- handshake snapshots (taken at negedge) ----------------
  logic       rst_s = 0, ar_hs_s = 0, r_hs_s = 0;
  logic [3:0] s_arid_s = 0;
  logic [3:0] arid_log[$];

  // ---------------- reference model ----------------
  // A transaction view: busy = a read was accepted from a master,
  // issued = the SRAM has accepted its address.
  typedef struct packed {
    logic        busy;
    logic        issued;
    logic        owner;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  id;
  } txn_t;

  txn_t cur = '0;
  logic last_m = 1'b1;
  bit   mdl_ok = 0;
  logic g_ok, g, in_r, in_ar, own_rdy;

  always @(negedge clk) begin
    rst_s    = rst;
    ar_hs_s  = s_arvalid & s_arready;
    r_hs_s   = s_rvalid & s_rready;
    s_arid_s = s_arid;
    if (ar_hs_s === 1'b1) arid_log.push_back(s_arid);

    in_ar   = cur.busy && !cur.issued;
    in_r    = cur.busy && cur.issued;
    own_rdy = cur.owner ? m1_rready : m0_rready;
    g_ok = 0;
    g    = 0;
    if (!cur.busy) begin
      if (m0_arvalid && m1_arvalid) begin g_ok = 1; g = !last_m; end
      else if (m0_arvalid)          begin g_ok = 1; g = 0; end
      else if (m1_arvalid)          begin g_ok = 1; g = 1; end
    end

    if (mdl_ok) begin
      check("m0_arready", m0_arready, g_ok && !g);
      check("m1_arready", m1_arready, g_ok && g);
      check("s_arvalid", s_arvalid, in_ar);
      check("s_rready", s_rready, in_r && own_rdy);
      check("m0_rvalid", m0_rvalid, in_r && !cur.owner && s_rvalid);
      check("m1_rvalid", m1_rvalid, in_r && cur.owner && s_rvalid);
      check("dbg_state", dbg_state, in_r ? 2 : (in_ar ? 1 : 0));
      if (in_ar) begin
        check("s_araddr", s_araddr, cur.addr);
        check("s_arsize", s_arsize, cur.size);
        check("s_arid", s_arid, cur.id);
      end
      if (in_r) begin
        check("m0_rdata", m0_rdata, s_rdata);
        check("m1_rdata", m1_rdata, s_rdata);
      end
    end

    if (rst) begin
      cur    = '0;
      last_m = 1'b1;
      mdl_ok = 1;
    end else if (mdl_ok) begin
      if (!cur.busy) begin
        if (g_ok) begin
          cur.busy   = 1;
          cur.issued = 0;
          cur.owner  = g;
          cur.addr   = g ? m1_araddr : m0_araddr;
          cur.size   = g ? m1_arsize : 3'b010;
          cur.id     = g ? 4'd1 : 4'd0;
        end
      end else if (!cur.issued) begin
        if (s_arready) cur.issued = 1;
      end else if (s_rvalid && own_rdy) begin
        last_m   = cur.owner;
        cur.busy = 0;
      end
    end
  end

  // ---------------- SRAM responder ----------------
  bit          sram_rand = 0;
  int          sram_lat  = 0;
  bit          sram_fixed_en = 1;
  logic [31:0] sram_fixed = 32'hDEAD_BEEF;
  bit          pend = 0;
  int          dly = 0;
  logic [3:0]  pend_id = 0;

  always @(posedge clk) begin
    #1;
    if (rst_s) begin
      s_arready = 0;
      s_rvalid  = 0;
      pend      = 0;
    end else begin
      if (r_hs_s) s_rvalid = 0;
      if (ar_hs_s) begin
        pend    = 1;
        pend_id = s_arid_s;
        dly     = sram_rand ? int'($urandom_range(0, 4)) : sram_lat;
      end
      if (pend && !s_rvalid) begin
        if (dly == 0) begin
          s_rvalid = 1;
          s_rdata  = sram_fixed_en ? sram_fixed : $urandom;
          s_rid    = pend_id;
          pend     = 0;
        end else begin
          dly--;
        end
      end
      s_arready = sram_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1; m0_arvalid = 0; m1_arvalid = 0;
    repeat (n) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic do_read(input bit m, input logic [31:0] addr, input logic [2:0] size,
                         input logic [2:0] exp_size, input logic [3:0] exp_id,
                         input logic [31:0] exp_data);
    int t;
    @(posedge clk); #1;
    if (m) begin m1_arvalid = 1; m1_araddr = addr; m1_arsize = size; end
    else   begin m0_arvalid = 1; m0_araddr = addr; end
    t = 0;
    do begin @(negedge clk); t++; end
    while (!(m ? (m1_arvalid && m1_arready) : (m0_arvalid && m0_arready)) && t < 20);
    check("grant_in_time", t < 20, 1);
    @(posedge clk); #1;
    if (m) m1_arvalid = 0; else m0_arvalid = 0;
    t = 0;
    while (!s_arvalid && t < 20) begin @(negedge clk); t++; end
    check("s_arvalid_in_time", t < 20, 1);
    check("lit_s_araddr", s_araddr, addr);
    check("lit_s_arsize", s_arsize, exp_size);
    check("lit_s_arid", s_arid, exp_id);
    t = 0;
    do begin @(negedge clk); t++; end
    while (!(m ? m1_rvalid : m0_rvalid) && t < 30);
    check("rvalid_in_time", t < 30, 1);
    check("lit_rdata", m ? m1_rdata : m0_rdata, exp_data);
    check("lit_other_rvalid", m ? m0_rvalid : m1_rvalid, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  logic [3:0] exp_ids[4] = '{4'd0, 4'd1, 4'd0, 4'd1};

  initial begin
    int t;

    // 1: reset, idle outputs
    do_reset(2);
    @(negedge clk);
    check("rst_s_arvalid", s_arvalid, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    check("rst_m0_arready", m0_arready, 0);
    check("rst_m1_arready", m1_arready, 0);
    check("rst_state", dbg_state, 0);

    // 2: single M0 read
    do_read(0, 32'h8000_0000, 3'b111, 3'b010, 4'd0, 32'hDEAD_BEEF);

    // 3: tie sequence from a fresh reset
    do_reset(1);
    arid_log.delete();
    @(posedge clk); #1;
    m0_arvalid = 1; m0_araddr = 32'h8000_0100;
    m1_arvalid = 1; m1_araddr = 32'h8000_0200; m1_arsize = 3'b010;
    t = 0;
    while (arid_log.size() < 4 && t < 100) begin @(negedge clk); t++; end
    check("tie_in_time", t < 100, 1);
    @(posedge clk); #1;
    m0_arvalid = 0; m1_arvalid = 0;
    for (int i = 0; i < 4; i++)
      check("tie_arid_seq", (arid_log.size() > i) ? arid_log[i] : 4'hF, exp_ids[i]);
    repeat (10) @(posedge clk);

    // 4: M1 byte read
    do_read(1, 32'h8000_0003, 3'b000, 3'b000, 4'd1, 32'hDEAD_BEEF);

    // 5: backpressure on M0 while M1 waits
    do_reset(1);
    @(posedge clk); #1;
    m0_rready = 0; m0_arvalid = 1; m0_araddr = 32'h8000_0040;
    t = 0;
    do begin @(negedge clk); t++; end while (!(m0_arvalid && m0_arready) && t < 20);
    check("bp_grant_in_time", t < 20, 1);
    @(posedge clk); #1;
    m0_arvalid = 0;
    m1_arvalid = 1; m1_araddr = 32'h8000_0080; m1_arsize = 3'b001;
    t = 0;
    do begin @(negedge clk); t++; end while (!m0_rvalid && t < 20);
    check("bp_rvalid_in_time", t < 20, 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_s_rready", s_rready, 0);
      check("bp_m0_rvalid", m0_rvalid, 1);
      check("bp_m1_arready", m1_arready, 0);
    end
    @(posedge clk); #1;
    m0_rready = 1;
    @(negedge clk);
    check("bp_release_s_rready", s_rready, 1);
    @(negedge clk);
    check("bp_m1_granted_next", m1_arready, 1);
    @(posedge clk); #1;
    m1_arvalid = 0;
    t = 0;
    do begin @(negedge clk); t++; end while (!m1_rvalid && t < 20);
    check("bp_m1_done", t < 20, 1);
    repeat (3) @(posedge clk);

    // 6: reset while waiting in R
    sram_lat = 6;
    @(posedge clk); #1;
    m0_arvalid = 1; m0_araddr = 32'h8000_0400;
    t = 0;
    do begin @(negedge clk); t++; end while (!(s_arvalid && s_arready) && t < 20);
    check("r6_ar_in_time", t < 20, 1);
    @(posedge clk); #1;
    m0_arvalid = 0;
    @(negedge clk);
    check("r6_in_r_no_data", m0_rvalid, 0);
    check("r6_in_r_state", dbg_state, 2);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("r6_state_idle", dbg_state, 0);
    check("r6_m0_rvalid", m0_rvalid, 0);
    check("r6_m1_rvalid", m1_rvalid, 0);
    sram_lat = 0;
    sram_fixed = 32'h1234_5678;
    do_read(1, 32'h8000_0020, 3'b001, 3'b001, 4'd1, 32'h1234_5678);

    // Randomised traffic against the model
    sram_rand = 1;
    sram_fixed_en = 0;
    repeat (3000) begin
      @(posedge clk); #1;
      if (m0_arvalid && m0_arready === 1'b0 && $urandom_range(0, 9) == 0) m0_arvalid = 0;
      if (!m0_arvalid && $urandom_range(0, 1) == 1) begin
        m0_arvalid = 1; m0_araddr = $urandom;
      end
      if (m1_arvalid && m1_arready === 1'b0 && $urandom_range(0, 9) == 0) m1_arvalid = 0;
      if (!m1_arvalid && $urandom_range(0, 1) == 1) begin
        m1_arvalid = 1; m1_araddr = $urandom; m1_arsize = 3'($urandom_range(0, 2));
      end
      m0_rready = ($urandom_range(0, 3) != 0);
      m1_rready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (m0_arvalid && m0_arready) begin @(posedge clk); #1 m0_arvalid = 0; end
      if (m1_arvalid && m1_arready) begin @(posedge clk); #1 m1_arvalid = 0; end
    end
    m0_arvalid = 0; m1_arvalid = 0; m0_rready = 1; m1_rready = 1;
    repeat (30) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
